// File: rtl/pool_result_collector.sv
// pool_result_collector
//   Collects pooled feature maps into NBANK history banks (one bank per
//   history tag). When every bank holds a complete map, or on flush, it
//   streams the full banks out in bank-major, address-ascending order.
//
// Ports
//   clk, reset_n           clock, async active-low reset
//   pool_result/addr/
//   history/com_end        result write strobe into bank[history][addr]
//   done_pool              marks bank[history] complete
//   flush                  drain only the banks currently marked full
//   o_data/o_bank/o_addr/
//   o_valid/o_ready        drained word, valid/ready handshake
//   busy                   high while draining; upstream must hold off
//   drain_done             one-cycle pulse after the last word is accepted
//   err                    sticky: dropped or out-of-range write
module pool_result_collector #(
  parameter int OSIZE = 7,
  parameter int NBANK = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] pool_result,
  input  logic [15:0]   addr,
  input  logic [1:0]    history,
  input  logic          com_end,
  input  logic          done_pool,
  input  logic          flush,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_bank,
  output logic [15:0]   o_addr,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          busy,
  output logic          drain_done,
  output logic          err
);

  localparam int MSZ   = OSIZE * OSIZE;
  localparam int DEPTH = NBANK * MSZ;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    rd_q;
  logic [NBANK-1:0] bank_full, bank_full_nxt;

  // Drain pipeline: [0] issue (address counters), [1] memory read, [2] output.
  logic [2:0]  vld_pipe;
  logic [2:1]  last_pipe;
  logic [1:0]  cur_bank, s1_bank;
  logic [15:0] cur_addr, s1_addr;

  logic collect, in_range, addr_ok, wr_ok, bad_wr;
  logic go_drain, accept, adv, last_beat, iss_last;
  logic [2:0] first_hit, next_hit;   // {found, bank}
  logic [IW-1:0] wr_idx, rd_idx;

  // Lowest full bank at or above 'from'; MSB flags whether one exists.
  function automatic logic [2:0] find_full(input logic [NBANK-1:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = NBANK-1; i >= 0; i--)
      if (i >= from && m[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  assign collect  = (state_q == COLLECT);
  assign in_range = ({30'b0, history} < NBANK);
  assign addr_ok  = ({16'b0, addr} < MSZ);
  assign wr_ok    = collect && com_end && in_range && addr_ok;
  assign bad_wr   = (com_end && !wr_ok) || (!collect && done_pool);

  always_comb begin
    bank_full_nxt = bank_full;
    if (collect && done_pool && in_range) bank_full_nxt[history] = 1'b1;
  end

  assign go_drain  = collect && ((&bank_full) || (flush && (|bank_full)));
  assign accept    = o_valid && o_ready;
  assign adv       = !o_valid || o_ready;   // whole pipe stalls on backpressure
  assign last_beat = accept && last_pipe[2];

  // The drain set may include a bank completed in the entry cycle.
  assign first_hit = find_full(bank_full_nxt, 0);
  assign next_hit  = find_full(bank_full, int'(cur_bank) + 1);
  assign iss_last  = (cur_addr == 16'(MSZ-1)) && !next_hit[2];

  assign wr_idx = IW'(int'(history) * MSZ + int'(addr));
  assign rd_idx = IW'(int'(cur_bank) * MSZ + int'(cur_addr));

  assign o_valid = vld_pipe[2];
  assign busy    = (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (go_drain)  state_d = DRAIN;
      DRAIN:   if (last_beat) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
  end

  // Storage: synchronous write, synchronous read (1-cycle latency).
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= pool_result;
    if (adv)   rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= COLLECT;
      bank_full  <= '0;
      err        <= 1'b0;
      drain_done <= 1'b0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      cur_bank   <= '0;
      cur_addr   <= '0;
      s1_bank    <= '0;
      s1_addr    <= '0;
      o_data     <= '0;
      o_bank     <= '0;
      o_addr     <= '0;
    end else begin
      state_q    <= state_d;
      err        <= err | bad_wr;
      drain_done <= last_beat;

      if (collect)        bank_full <= bank_full_nxt;
      else if (last_beat) bank_full <= '0;

      // Issue counters: address wraps per bank, bank stops at the last full one.
      if (go_drain) begin
        cur_bank    <= first_hit[1:0];
        cur_addr    <= '0;
        vld_pipe[0] <= 1'b1;
      end else if (!collect && adv && vld_pipe[0]) begin
        if (cur_addr == 16'(MSZ-1)) begin
          cur_addr <= '0;
          if (next_hit[2]) cur_bank    <= next_hit[1:0];
          else             vld_pipe[0] <= 1'b0;
        end else begin
          cur_addr <= cur_addr + 16'd1;
        end
      end

      if (!collect && adv) begin
        vld_pipe[1]  <= vld_pipe[0];
        last_pipe[1] <= vld_pipe[0] && iss_last;
        s1_bank      <= cur_bank;
        s1_addr      <= cur_addr;
        vld_pipe[2]  <= vld_pipe[1];
        last_pipe[2] <= last_pipe[1];
        if (vld_pipe[1]) begin
          o_data <= rd_q;
          o_bank <= s1_bank;
          o_addr <= s1_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_result_collector.sv
module tb_pool_result_collector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, com_end, done_pool, flush, o_ready;
  logic [15:0] pool_result, addr;
  logic [1:0]  history;
  logic [15:0] o_data, o_addr;
  logic [1:0]  o_bank;
  logic        o_valid, busy, drain_done, err;

  // Second instance with NBANK=2 for the out-of-range history check.
  logic        b_reset_n, b_com_end, b_done_pool, b_flush, b_o_ready;
  logic [15:0] b_pool_result, b_addr;
  logic [1:0]  b_history;
  logic [15:0] b_o_data, b_o_addr;
  logic [1:0]  b_o_bank;
  logic        b_o_valid, b_busy, b_drain_done, b_err;

  pool_result_collector #(.OSIZE(7), .NBANK(4), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n), .pool_result(pool_result), .addr(addr),
    .history(history), .com_end(com_end), .done_pool(done_pool), .flush(flush),
    .o_data(o_data), .o_bank(o_bank), .o_addr(o_addr), .o_valid(o_valid),
    .o_ready(o_ready), .busy(busy), .drain_done(drain_done), .err(err));

  pool_result_collector #(.OSIZE(7), .NBANK(2), .DW(16)) dut2 (
    .clk(clk), .reset_n(b_reset_n), .pool_result(b_pool_result), .addr(b_addr),
    .history(b_history), .com_end(b_com_end), .done_pool(b_done_pool), .flush(b_flush),
    .o_data(b_o_data), .o_bank(b_o_bank), .o_addr(b_o_addr), .o_valid(b_o_valid),
    .o_ready(b_o_ready), .busy(b_busy), .drain_done(b_drain_done), .err(b_err));

  int n_chk = 0, n_err = 0;
  logic [15:0] pat = 16'b1001_1101_0011_0110;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; b_reset_n = 1'b0;
    com_end = 0; done_pool = 0; flush = 0; o_ready = 1;
    pool_result = 0; addr = 0; history = 0;
    b_com_end = 0; b_done_pool = 0; b_flush = 0; b_o_ready = 1;
    b_pool_result = 0; b_addr = 0; b_history = 0;
    tick(); tick();
    reset_n = 1'b1; b_reset_n = 1'b1;
    tick();
  endtask

  task automatic wr(input int b, input int a, input logic [15:0] d);
    history = 2'(b); addr = 16'(a); pool_result = d; com_end = 1'b1;
    tick();
    com_end = 1'b0;
  endtask

  task automatic done(input int b);
    history = 2'(b); done_pool = 1'b1;
    tick();
    done_pool = 1'b0;
  endtask

  task automatic fill(input logic [3:0] mask);
    for (int b = 0; b < 4; b++)
      if (mask[b]) for (int a = 0; a < 49; a++) wr(b, a, 16'(b*100 + a));
    for (int b = 0; b < 4; b++)
      if (mask[b]) done(b);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      if (o_valid || busy || drain_done) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  // Consumes a drain, checking order/data per beat and hold while stalled.
  task automatic run_drain(input logic [3:0] mask, input bit bp, input int inject_at,
                           output int cyc);
    logic [33:0] exp_q[$];
    logic [33:0] held, got;
    bit stalled;
    int idx, dd;
    for (int b = 0; b < 4; b++)
      if (mask[b]) for (int a = 0; a < 49; a++) exp_q.push_back({2'(b), 16'(a), 16'(b*100 + a)});
    stalled = 0; idx = 0; dd = 0; cyc = 0; held = '0;
    while (cyc < 2000) begin
      o_ready = bp ? pat[cyc % 16] : 1'b1;
      if (cyc == inject_at) begin
        history = 2'd1; addr = 16'd5; pool_result = 16'hBEEF; com_end = 1'b1;
      end else begin
        com_end = 1'b0;
      end
      if (drain_done) begin dd++; break; end
      got = {o_bank, o_addr, o_data};
      if (stalled) check("stall_hold", {o_valid, got}, {1'b1, held});
      if (o_valid && o_ready) begin
        if (idx < exp_q.size()) check("beat", got, exp_q[idx]);
        else                    check("extra_beat", idx, exp_q.size());
        idx++;
      end
      stalled = o_valid && !o_ready;
      held = got;
      tick();
      cyc++;
    end
    com_end = 1'b0; o_ready = 1'b1;
    check("beat_count", idx, exp_q.size());
    check("drain_done_seen", dd, 1);
    check("ovalid_at_done", o_valid, 0);
    tick();
    check("drain_done_one_cycle", drain_done, 0);
    check("busy_after_drain", busy, 0);
  endtask

  initial begin
    int cyc, beats;
    do_reset();
    check("rst_o_valid", o_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_err", err, 0);
    check("rst_outputs", {o_bank, o_addr, o_data}, 0);

    // 1: full fill, o_ready held high
    fill(4'hF);
    tick();
    check("t1_busy_rise", busy, 1);
    check("t1_ovalid_entry", o_valid, 0);
    tick();
    check("t1_ovalid_plus1", o_valid, 0);
    tick();
    check("t1_ovalid_plus2", o_valid, 1);
    run_drain(4'hF, 1'b0, -1, cyc);
    check("t1_back_to_back", cyc, 196);
    check("t1_err", err, 0);

    // 2: same fill under backpressure
    fill(4'hF);
    run_drain(4'hF, 1'b1, -1, cyc);
    check("t2_err", err, 0);

    // 3: flush with nothing full, then partial banks 0 and 2
    do_reset();
    pulse_flush();
    quiet("t3_empty_flush", 20);
    fill(4'b0101);
    quiet("t3_partial_no_auto_drain", 5);
    pulse_flush();
    check("t3_busy", busy, 1);
    run_drain(4'b0101, 1'b0, -1, cyc);

    // 4: boundaries
    do_reset();
    check("t4_b_err_rst", b_err, 0);
    wr(0, 49, 16'h1234);
    check("t4_addr49_err", err, 1);
    b_history = 2'd3; b_addr = 16'd0; b_pool_result = 16'h55; b_com_end = 1'b1;
    tick();
    b_com_end = 1'b0;
    check("t4_hist3_err", b_err, 1);
    for (int a = 0; a < 48; a++) wr(0, a, 16'(a));
    wr(0, 48, 16'd999);
    history = 2'd0; addr = 16'd48; pool_result = 16'd48; com_end = 1'b1; done_pool = 1'b1;
    tick();
    com_end = 1'b0; done_pool = 1'b0;
    check("t4_no_auto_drain", busy, 0);
    pulse_flush();
    check("t4_flush_busy", busy, 1);
    run_drain(4'b0001, 1'b0, -1, cyc);

    // 5: write during drain is dropped
    do_reset();
    check("t5_err_clear", err, 0);
    fill(4'hF);
    run_drain(4'hF, 1'b0, 10, cyc);
    check("t5_err_set", err, 1);

    // 6: reset mid-drain
    do_reset();
    fill(4'hF);
    beats = 0; cyc = 0;
    o_ready = 1'b1;
    while (beats < 10 && cyc < 100) begin
      if (o_valid) beats++;
      tick();
      cyc++;
    end
    check("t6_beats_before_reset", beats, 10);
    reset_n = 1'b0;
    #1;
    check("t6_async_ovalid", o_valid, 0);
    check("t6_async_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_flush();
    quiet("t6_flush_after_reset", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
